// File: rtl/pipeline_pkg.sv
// pipeline_pkg: EXE/MEM and MEM/WB word layouts plus the memory-stage state type.
// No ports; imported by mem_access_stage and mem_wb_register.
package pipeline_pkg;
   localparam int EXE_MEM_W = 39;
   localparam int MEM_WB_W  = 21;
   localparam int ADDR_W    = 16;
   localparam int DATA_W    = 16;
   localparam int DEST_W    = 4;
   localparam int EM_RESULT_LSB = 0;
   localparam int EM_DEST_LSB   = 16;
   localparam int EM_WB_LSB     = 20;
   localparam int EM_RD_LSB     = 21;
   localparam int EM_WR_LSB     = 22;
   localparam int EM_ADDR_LSB   = 23;
   localparam int MW_DATA_LSB   = 0;
   localparam int MW_DEST_LSB   = 16;
   localparam int MW_WB_LSB     = 20;
   typedef struct packed {
      logic [ADDR_W-1:0] dir_mem;
      logic              mem_wr;
      logic              mem_rd;
      logic              write_back;
      logic [DEST_W-1:0] destiny;
      logic [DATA_W-1:0] result;
   } exe_mem_t;
   typedef struct packed {
      logic              write_back;
      logic [DEST_W-1:0] destiny;
      logic [DATA_W-1:0] data;
   } mem_wb_t;
   typedef enum logic {IDLE, ACCESS} mem_state_t;
endpackage

// File: rtl/mem_wb_register.sv
// mem_wb_register: MEM/WB output register with sync active-low reset and load enable.
// Ports: clock, reset_n, en (load enable), d (next word), q (registered word).
module mem_wb_register
   import pipeline_pkg::*;
(
   input  logic                clock,
   input  logic                reset_n,
   input  logic                en,
   input  logic [MEM_WB_W-1:0] d,
   output logic [MEM_WB_W-1:0] q
);
   always_ff @(posedge clock) begin
      if (!reset_n) q <= '0;
      else if (en) q <= d;
   end
endmodule

// File: rtl/mem_access_stage.sv
// mem_access_stage: unpacks the EXE/MEM word, runs one data-memory load/store via req/ack, emits MEM/WB.
// Ports: clock, reset_n (sync, active low); exe_mem_in (39-bit word); mem_req/mem_we/mem_addr/mem_wdata
// to memory, mem_ack/mem_rdata from memory; stall to upstream; mem_wb_out to write-back;
// err_illegal / err_timeout sticky error flags.
module mem_access_stage
   import pipeline_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                 clock,
   input  logic                 reset_n,
   input  logic [EXE_MEM_W-1:0] exe_mem_in,
   output logic                 mem_req,
   output logic                 mem_we,
   output logic [ADDR_W-1:0]    mem_addr,
   output logic [DATA_W-1:0]    mem_wdata,
   input  logic                 mem_ack,
   input  logic [DATA_W-1:0]    mem_rdata,
   output logic                 stall,
   output logic [MEM_WB_W-1:0]  mem_wb_out,
   output logic                 err_illegal,
   output logic                 err_timeout
);
   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
   exe_mem_t          w_in;
   mem_wb_t           w_wb_d;
   logic              w_is_acc;
   logic              w_illegal;
   logic              w_last;
   mem_state_t        r_state;
   logic              r_req;
   logic              r_we;
   logic [ADDR_W-1:0] r_addr;
   logic [DATA_W-1:0] r_wdata;
   logic              r_wb;
   logic [DEST_W-1:0] r_dest;
   logic [CW-1:0]     r_cnt;
   logic              r_err_ill;
   logic              r_err_to;
   assign w_in      = exe_mem_in;
   assign w_is_acc  = w_in.mem_rd ^ w_in.mem_wr;
   assign w_illegal = w_in.mem_rd & w_in.mem_wr;
   assign w_last    = r_cnt == CW'(TIMEOUT_CYCLES - 1);
   assign stall     = (r_state == IDLE) ? w_is_acc : !mem_ack;
   assign mem_req     = r_req;
   assign mem_we      = r_we;
   assign mem_addr    = r_addr;
   assign mem_wdata   = r_wdata;
   assign err_illegal = r_err_ill;
   assign err_timeout = r_err_to;
   // Every path not listed below writes a bubble: access start, wait, timeout, illegal word.
   always_comb begin
      w_wb_d = '0;
      if (r_state == IDLE && !w_in.mem_rd && !w_in.mem_wr)
         w_wb_d = {w_in.write_back, w_in.destiny, w_in.result};
      else if (r_state == ACCESS && mem_ack)
         w_wb_d = {r_wb, r_dest, r_we ? r_wdata : mem_rdata};
   end
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         r_state   <= IDLE;
         r_req     <= 1'b0;
         r_we      <= 1'b0;
         r_addr    <= '0;
         r_wdata   <= '0;
         r_wb      <= 1'b0;
         r_dest    <= '0;
         r_cnt     <= '0;
         r_err_ill <= 1'b0;
         r_err_to  <= 1'b0;
      end else if (r_state == IDLE) begin
         if (w_illegal) r_err_ill <= 1'b1;
         if (w_is_acc) begin
            r_state <= ACCESS;
            r_req   <= 1'b1;
            r_we    <= w_in.mem_wr;
            r_addr  <= w_in.dir_mem;
            r_wdata <= w_in.result;
            r_wb    <= w_in.write_back;
            r_dest  <= w_in.destiny;
            r_cnt   <= '0;
         end
      end else if (mem_ack || w_last) begin
         r_state <= IDLE;
         r_req   <= 1'b0;
         r_cnt   <= '0;
         if (!mem_ack) r_err_to <= 1'b1;
      end else begin
         r_cnt <= r_cnt + 1'b1;
      end
   end
   mem_wb_register u_mem_wb (
      .clock   (clock),
      .reset_n (reset_n),
      .en      (1'b1),
      .d       (w_wb_d),
      .q       (mem_wb_out)
   );
endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- Consumer end of the 39-bit EXE/MEM pipeline word.
- Unpacks the word and performs the data-memory load or store it requests through a req/ack handshake.
- Stalls upstream while an access is outstanding.
- Emits the 21-bit MEM/WB word `{writeBack, destiny, data}` to the write-back stage.

Parameters:
- TIMEOUT_CYCLES, 255, maximum ACCESS cycles without mem_ack before the access is abandoned.

Ports:
- clock  in  1  rising-edge clock for all state.
- reset_n  in  1  synchronous active-low reset.
- exe_mem_in  in  39  EXE/MEM word:
  - [38:23] dir_mem
  - [22] mem_wr
  - [21] mem_rd
  - [20] writeBack
  - [19:16] destiny
  - [15:0] result
- mem_req  out  1  memory request, held until ack or timeout.
- mem_we  out  1  1 = store, 0 = load; valid while mem_req.
- mem_addr  out  16  latched dir_mem.
- mem_wdata  out  16  latched result (store data).
- mem_ack  in  1  memory completion, single-cycle pulse.
- mem_rdata  in  16  load data, valid with mem_ack.
- stall  out  1  combinational; upstream holds exe_mem_in while high.
- mem_wb_out  out  21  `{writeBack, destiny[3:0], data[15:0]}`.
- err_illegal  out  1  sticky: a word had mem_rd and mem_wr both set.
- err_timeout  out  1  sticky: an access timed out.

Behaviour:
- Reset (reset_n low at a rising edge) forces:
  - state IDLE
  - mem_req, mem_we = 0
  - mem_addr, mem_wdata = 0
  - mem_wb_out = 0
  - err_illegal, err_timeout = 0
  - timeout counter = 0
- Reset mid-access: mem_req is low from the next cycle. A later mem_ack is ignored.
- A word is an access when exactly one of mem_rd / mem_wr is 1. An all-zero word is a bubble.
- IDLE, non-access word: mem_wb_out <= `{writeBack, destiny, result}` at the next edge (latency 1). stall = 0.
- IDLE, access word:
  - stall = 1 this cycle.
  - At the edge, latch addr, wdata, we, writeBack and destiny, then go to ACCESS.
  - mem_wb_out <= bubble (all zero).
- IDLE, mem_rd and mem_wr both 1:
  - No memory access.
  - mem_wb_out <= bubble.
  - err_illegal <= 1.
  - stall = 0.
- ACCESS:
  - mem_req = 1 and mem_we = latched we, both registered outputs.
  - stall = !mem_ack.
  - exe_mem_in is ignored; the latched copy is used.
- ACCESS with mem_ack = 1:
  - Load: mem_wb_out <= `{wb_l, dest_l, mem_rdata}`.
  - Store: mem_wb_out <= `{wb_l, dest_l, wdata_l}`.
  - Go to IDLE; mem_req falls at the same edge.
  - Minimum access latency: request cycle plus 1 ACCESS cycle.
- ACCESS, no ack:
  - mem_wb_out <= bubble.
  - Counter increments.
  - When the counter reaches TIMEOUT_CYCLES-1 without ack: err_timeout <= 1, mem_wb_out <= bubble, go to IDLE, counter <= 0.
- Counter clears on every entry to ACCESS. Width is $clog2(TIMEOUT_CYCLES+1).
- mem_ack while IDLE is ignored.
- Back-to-back accesses: a new access word arriving on the ack cycle is sampled in IDLE the following cycle. There is no overlap, at most one outstanding access.
- Error flags are only cleared by reset.

Decomposition:
- Shared package pipeline_pkg holds:
  - EXE_MEM_W = 39 and MEM_WB_W = 21
  - field LSB/width constants for both words
  - the exe_mem_t / mem_wb_t packed structs
  - mem_state_t {IDLE, ACCESS}
- One natural sub-module: mem_wb_register. It is a 21-bit output register with synchronous active-low reset and a load enable; its data mux sits in the parent.

Test Plan:
- ALU passthrough: exe_mem_in = `{16'h0000, 0, 0, 1, 4'h5, 16'hBEEF}`, held 1 cycle → next cycle mem_wb_out = `{1, 4'h5, 16'hBEEF}`; stall = 0; mem_req never asserted.
- Load with ack on first ACCESS cycle: dir_mem = 16'h0040, mem_rd = 1, writeBack = 1, destiny = 3, memory returns 16'h1234 → checks:
  - stall high for 1 cycle
  - mem_req high 1 cycle with mem_addr = 16'h0040, mem_we = 0
  - mem_wb_out = `{1, 4'h3, 16'h1234}` the cycle after the ack
- Store with 4-cycle ack delay: dir_mem = 16'h0010, result = 16'hCAFE, mem_wr = 1, writeBack = 0 → checks:
  - mem_we = 1, mem_wdata = 16'hCAFE
  - stall high 4 cycles
  - mem_wb_out bubble during the wait
  - exe_mem_in changed mid-wait does not alter mem_addr
- Timeout with TIMEOUT_CYCLES = 8, no ack → mem_req drops after 8 ACCESS cycles, err_timeout = 1 sticky, mem_wb_out = 0, stall = 0; a following passthrough word completes normally.
- Illegal word mem_rd = mem_wr = 1 → no mem_req, err_illegal = 1, mem_wb_out = 0.
- Reset during ACCESS: reset_n low 1 cycle during ACCESS → mem_req = 0 and all outputs zero the next cycle; a late mem_ack produces no write-back.
